moore_detect_sequencer: RTL and testbench

//  Sequencer for the team's two-consecutive-ones Moore detector (1-bit input w, registered state output z).

---
 rtl/moore_detect_sequencer.sv | 108 ++++++++++
 tb/tb_moore_detect_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/moore_detect_sequencer.sv
// moore_detect_sequencer: serialises a word MSB-first into a two-ones Moore detector and counts its z-high cycles
//   clk_i        rising-edge clock shared with the detector
//   rst_ni       asynchronous active-low reset
//   start_i      accept data_in_i (IDLE only)
//   abort_i      synchronous cancel of an in-flight word
//   data_in_i    word to serialise
//   z_i          detector output
//   w_o          registered serial bit to the detector
//   busy_o       high in SHIFT and DRAIN
//   done_o       one-cycle pulse, det_count_o valid
//   det_count_o  z-high cycles of the last completed word
module moore_detect_sequencer #(
  parameter int WIDTH = 8,
  parameter int DRAIN_CYC = 2,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             z_i,
  output logic             w_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] det_count_o
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam int CW = $clog2(WIDTH + DRAIN_CYC + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
  logic [1:0] state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic w_q, w_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] zc_q, zc_d, zc_n, det_q, det_d;
  // sr_q holds the bits still to be sent after the one currently on w
  assign zc_n = (z_i && !(&zc_q)) ? zc_q + CNT_W'(1) : zc_q;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    w_d = w_q;
    cnt_d = cnt_q;
    zc_d = zc_q;
    det_d = det_q;
    case (state_q)
      S_IDLE: begin
        w_d = 1'b0;
        if (start_i && !abort_i) begin
          sr_d = {data_in_i[WIDTH-2:0], 1'b0};
          w_d = data_in_i[WIDTH-1];
          cnt_d = '0;
          zc_d = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        zc_d = zc_n;
        if (abort_i) begin
          w_d = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == SHIFT_LAST) begin
          w_d = 1'b0;
          cnt_d = '0;
          state_d = S_DRAIN;
        end else begin
          w_d = sr_q[WIDTH-1];
          sr_d = sr_q << 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        zc_d = zc_n;
        w_d = 1'b0;
        if (abort_i) state_d = S_IDLE;
        else if (cnt_q == DRAIN_LAST) begin
          det_d = zc_n;
          state_d = S_DONE;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        w_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sr_q <= '0;
      w_q <= 1'b0;
      cnt_q <= '0;
      zc_q <= '0;
      det_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      w_q <= w_d;
      cnt_q <= cnt_d;
      zc_q <= zc_d;
      det_q <= det_d;
    end
  end
  assign w_o = w_q;
  assign busy_o = (state_q == S_SHIFT) || (state_q == S_DRAIN);
  assign done_o = state_q == S_DONE;
  assign det_count_o = det_q;
endmodule

// File: tb/tb_moore_detect_sequencer.sv
// tb_moore_detect_sequencer: scoreboard bench driving the sequencer into a behavioural two-ones detector
module tb_moore_detect_sequencer;
  localparam int WIDTH = 8;
  localparam int DRAIN = 2;
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef struct { int cnt; int t; } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [WIDTH-1:0] data = '0;
  logic z;
  logic w, busy, done;
  logic [CNT_W-1:0] det_count;
  logic [1:0] ds;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  moore_detect_sequencer #(.WIDTH(WIDTH), .DRAIN_CYC(DRAIN)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .data_in_i(data),
    .z_i(z), .w_o(w), .busy_o(busy), .done_o(done), .det_count_o(det_count)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ds <= 2'd0;
    else ds <= w ? ((ds == 2'd0) ? 2'd1 : 2'd2) : 2'd0;
  end
  assign z = ds == 2'd2;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int ref_count(input logic [WIDTH-1:0] d);
    int s = 0;
    int c = 0;
    logic b;
    for (int i = 0; i < WIDTH + DRAIN; i++) begin
      b = (i < WIDTH) ? d[WIDTH-1-i] : 1'b0;
      c += (s == 2) ? 1 : 0;
      s = b ? ((s == 0) ? 1 : 2) : 0;
    end
    return c;
  endfunction
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) check("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("det_count", int'(det_count), e.cnt);
        check("latency", cyc - e.t, WIDTH + DRAIN);
      end
    end
  end
  task automatic push(input logic [WIDTH-1:0] d);
    exp_t e;
    e.cnt = ref_count(d);
    e.t = cyc;
    sb.push_back(e);
  endtask
  task automatic run_word(input logic [WIDTH-1:0] d, input int glitch);
    @(negedge clk);
    start = 1'b1;
    data = d;
    @(posedge clk);
    #1;
    push(d);
    start = 1'b0;
    for (int i = 0; i < WIDTH + DRAIN; i++) begin
      @(negedge clk);
      start = (i == glitch);
      data = (i == glitch) ? 8'hFF : d;
      check("w", int'(w), (i < WIDTH) ? int'(d[WIDTH-1-i]) : 0);
      check("busy", int'(busy), 1);
    end
    @(negedge clk);
    start = 1'b0;
    check("done", int'(done), 1);
    check("busy_done", int'(busy), 0);
  endtask
  initial begin
    #5;
    check("rst_w", int'(w), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(det_count), 0);
    #10 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_w", int'(w), 0);
    run_word(8'hF0, -1);
    run_word(8'hFF, -1);
    run_word(8'hAA, -1);
    run_word(8'hCC, -1);
    run_word(8'h5B, 3);
    // start held high across two words; the second is taken the cycle after done
    @(negedge clk);
    start = 1'b1;
    data = 8'hF0;
    @(posedge clk);
    #1 push(8'hF0);
    @(negedge clk);
    data = 8'h0F;
    repeat (WIDTH + DRAIN + 2) @(posedge clk);
    #1 push(8'h0F);
    start = 1'b0;
    repeat (WIDTH + DRAIN + 2) @(negedge clk);
    check("b2b_drained", sb.size(), 0);
    check("b2b_count", int'(det_count), 3);
    // abort wins over start in IDLE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort_busy", int'(busy), 0);
    // abort in the third SHIFT cycle
    @(negedge clk);
    start = 1'b1;
    data = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_w", int'(w), 0);
    check("abort_done", int'(done), 0);
    check("abort_count", int'(det_count), 3);
    repeat (WIDTH + DRAIN + 2) @(negedge clk);
    check("abort_count_held", int'(det_count), 3);
    // reset in the middle of a word
    run_word(8'hCC, -1);
    @(negedge clk);
    start = 1'b1;
    data = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_w", int'(w), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_count", int'(det_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_word(8'hCC, -1);
    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
